// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like port between inst and data requesters; grant 1 cycle after IDLE sees a request, >=3 cycles/txn.
// Backpressure: bus_addr_ok stalls hold bus_req and latched fields; the losing requester holds its request until a later IDLE.
module mem_bus_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_last_data;
    logic        r_bus_req;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;

    logic w_any_req;
    logic w_pick_data;
    logic w_accept;
    logic w_done;

    // Data wins by default; with RR_EN a pending inst request takes the turn after a data grant.
    assign w_any_req   = inst_req | data_req;
    assign w_pick_data = data_req & ~(RR_EN & r_last_data & inst_req);
    assign w_accept    = (r_state == ST_ADDR) & bus_addr_ok;
    assign w_done      = (r_state == ST_DATA) & bus_data_ok;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_last_data <= 1'b0;
            r_bus_req   <= 1'b0;
            r_wr        <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= 32'd0;
            r_wstrb     <= 4'd0;
            r_wdata     <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_pick_data;
                        r_last_data <= w_pick_data;
                        r_bus_req   <= 1'b1;
                        r_wr        <= w_pick_data ? data_wr    : inst_wr;
                        r_size      <= w_pick_data ? data_size  : inst_size;
                        r_addr      <= w_pick_data ? data_addr  : inst_addr;
                        r_wstrb     <= w_pick_data ? data_wstrb : inst_wstrb;
                        r_wdata     <= w_pick_data ? data_wdata : inst_wdata;
                        r_state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus_addr_ok) begin
                        r_bus_req <= 1'b0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bus_data_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_wr    = r_wr;
    assign bus_size  = r_size;
    assign bus_addr  = r_addr;
    assign bus_wstrb = r_wstrb;
    assign bus_wdata = r_wdata;

    // Handshake pulses are steered to the transaction owner only.
    assign inst_addr_ok = w_accept & ~r_owner;
    assign data_addr_ok = w_accept &  r_owner;
    assign inst_data_ok = w_done   & ~r_owner;
    assign data_data_ok = w_done   &  r_owner;
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? bus_rdata : 32'd0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Two arbiters (round-robin and strict data priority) driven by random requesters and a random bus,
// predicted by a transaction-level model and checked by a separate monitor through expectation queues.
module tb_mem_bus_arbiter;
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;
    typedef struct { int owner; req_t f; } acc_t;
    typedef struct { int owner; logic [31:0] rdata; } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn    [2];
    logic        req_v   [2][2];
    req_t        rq      [2][2];
    logic        b_aok   [2];
    logic        b_dok   [2];
    logic [31:0] b_rdata [2];
    logic        o_aok   [2][2];
    logic        o_dok   [2][2];
    logic [31:0] o_rdata [2][2];
    logic        o_breq  [2];
    logic        o_bwr   [2];
    logic [1:0]  o_bsize [2];
    logic [31:0] o_baddr [2];
    logic [3:0]  o_bwstrb[2];
    logic [31:0] o_bwdata[2];

    // Instance 0 uses round-robin override, instance 1 strict data priority.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_bus_arbiter #(.RR_EN(g == 0)) u_dut (
            .clk          (clk),
            .resetn       (rstn[g]),
            .inst_req     (req_v[g][0]),
            .inst_wr      (rq[g][0].wr),
            .inst_size    (rq[g][0].size),
            .inst_addr    (rq[g][0].addr),
            .inst_wstrb   (rq[g][0].wstrb),
            .inst_wdata   (rq[g][0].wdata),
            .inst_addr_ok (o_aok[g][0]),
            .inst_data_ok (o_dok[g][0]),
            .inst_rdata   (o_rdata[g][0]),
            .data_req     (req_v[g][1]),
            .data_wr      (rq[g][1].wr),
            .data_size    (rq[g][1].size),
            .data_addr    (rq[g][1].addr),
            .data_wstrb   (rq[g][1].wstrb),
            .data_wdata   (rq[g][1].wdata),
            .data_addr_ok (o_aok[g][1]),
            .data_data_ok (o_dok[g][1]),
            .data_rdata   (o_rdata[g][1]),
            .bus_req      (o_breq[g]),
            .bus_wr       (o_bwr[g]),
            .bus_size     (o_bsize[g]),
            .bus_addr     (o_baddr[g]),
            .bus_wstrb    (o_bwstrb[g]),
            .bus_wdata    (o_bwdata[g]),
            .bus_addr_ok  (b_aok[g]),
            .bus_data_ok  (b_dok[g]),
            .bus_rdata    (b_rdata[g])
        );
    end

    // Reference model: phase 0 = no transaction, 1 = granted awaiting accept, 2 = accepted awaiting completion.
    int   ph     [2];
    bit   last_d [2];
    int   own    [2];
    int   wcnt   [2];
    bit   pend   [2][2];
    acc_t acc_q  [2][$];
    rsp_t rsp_q  [2][$];
    int   cnt_aok[2][2];

    int p_new [2];
    int p_spur;
    int p_dok;
    int aok_delay;
    bit force_rd;
    bit force_dok;
    bit mon_off = 1'b1;
    int rst_run;
    int n_checks;
    int n_err;

    task automatic chk(input bit ok, input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.wr    = 1'($urandom_range(1));
        r.size  = 2'($urandom_range(2));
        r.addr  = $urandom;
        r.wstrb = 4'($urandom);
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic step(input bit rst);
        int w;
        @(negedge clk);
        mon_off = rst;
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                if (!rst && !pend[d][r] && $urandom_range(99) < p_new[r]) begin
                    pend[d][r] = 1'b1;
                    rq[d][r]   = rand_req();
                end
                req_v[d][r] = pend[d][r];
            end
            rstn[d]    = !rst;
            b_rdata[d] = force_rd ? 32'hDEAD_BEEF : $urandom;
            if (rst) begin
                b_aok[d] = 1'b0;
                b_dok[d] = 1'b0;
            end else begin
                if (ph[d] == 1) b_aok[d] = (aok_delay >= 0) ? (wcnt[d] >= aok_delay) : ($urandom_range(99) < 50);
                else            b_aok[d] = $urandom_range(99) < p_spur;
                if (ph[d] == 2) b_dok[d] = $urandom_range(99) < p_dok;
                else            b_dok[d] = force_dok || ($urandom_range(99) < p_spur);
            end
            if (rst) begin
                ph[d] = 0; last_d[d] = 1'b0; wcnt[d] = 0;
                acc_q[d].delete();
                rsp_q[d].delete();
            end else begin
                case (ph[d])
                    0: if (pend[d][0] || pend[d][1]) begin
                        if (!pend[d][0])      w = 1;
                        else if (!pend[d][1]) w = 0;
                        else                  w = (d == 0 && last_d[d]) ? 0 : 1;
                        acc_q[d].push_back('{w, rq[d][w]});
                        last_d[d] = (w == 1);
                        own[d]    = w;
                        wcnt[d]   = 0;
                        ph[d]     = 1;
                    end
                    1: if (b_aok[d]) begin
                        pend[d][own[d]] = 1'b0;
                        ph[d] = 2;
                    end else begin
                        wcnt[d]++;
                    end
                    default: if (b_dok[d]) begin
                        rsp_q[d].push_back('{own[d], b_rdata[d]});
                        ph[d] = 0;
                    end
                endcase
            end
        end
        if (rst) begin
            rst_run++;
            if (rst_run >= 2) begin
                #2;
                for (int d = 0; d < 2; d++) begin
                    chk({o_breq[d], o_bwr[d], o_bsize[d], o_baddr[d], o_bwstrb[d], o_bwdata[d]} == '0,
                        "reset_bus_out", {o_breq[d], o_bwr[d], o_bsize[d], o_baddr[d], o_bwstrb[d], o_bwdata[d]}, 0);
                    chk({o_aok[d][0], o_aok[d][1], o_dok[d][0], o_dok[d][1], o_rdata[d][0], o_rdata[d][1]} == '0,
                        "reset_rsp_out", {o_aok[d][0], o_aok[d][1], o_dok[d][0], o_dok[d][1], o_rdata[d][0], o_rdata[d][1]}, 0);
                end
            end
        end else begin
            rst_run = 0;
        end
    endtask

    function automatic bit model_idle();
        return ph[0] == 0 && ph[1] == 0 && !pend[0][0] && !pend[0][1] && !pend[1][0] && !pend[1][1];
    endfunction

    task automatic drain();
        p_new = '{0, 0};
        for (int i = 0; i < 400; i++) begin
            if (model_idle()) break;
            step(1'b0);
        end
        chk(model_idle(), "drain_timeout", {ph[0], ph[1]}, 0);
        #3;
    endtask

    // Monitor: consumes expectations whenever a DUT presents a bus request or handshake pulse.
    initial begin
        acc_t e;
        rsp_t e2;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_off) begin
                for (int d = 0; d < 2; d++) begin
                    if (o_aok[d][0] && o_aok[d][1]) chk(1'b0, "both_addr_ok", 3, 0);
                    if (o_dok[d][0] && o_dok[d][1]) chk(1'b0, "both_data_ok", 3, 0);
                    if (o_breq[d]) begin
                        if (acc_q[d].size() == 0) chk(1'b0, "bus_req_unexpected", d, 0);
                        else chk({o_bwr[d], o_bsize[d], o_baddr[d], o_bwstrb[d], o_bwdata[d]} == acc_q[d][0].f, "bus_fields",
                                 {o_bwr[d], o_bsize[d], o_baddr[d], o_bwstrb[d], o_bwdata[d]}, acc_q[d][0].f);
                    end
                    for (int r = 0; r < 2; r++) begin
                        if (o_aok[d][r]) begin
                            cnt_aok[d][r]++;
                            if (acc_q[d].size() == 0) chk(1'b0, "addr_ok_spurious", r, 0);
                            else begin
                                e = acc_q[d].pop_front();
                                chk(e.owner == r, "addr_ok_owner", r, e.owner);
                            end
                        end
                        if (o_dok[d][r]) begin
                            if (rsp_q[d].size() == 0) chk(1'b0, "data_ok_spurious", r, 0);
                            else begin
                                e2 = rsp_q[d].pop_front();
                                chk(e2.owner == r && o_rdata[d][r] == e2.rdata, "data_ok_rdata",
                                    {r, o_rdata[d][r]}, {e2.owner, e2.rdata});
                            end
                        end else begin
                            chk(o_rdata[d][r] == 32'd0, "rdata_idle_zero", o_rdata[d][r], 0);
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit ok;
        n_checks = 0; n_err = 0; rst_run = 0;
        p_spur = 0; p_dok = 100; aok_delay = -1; force_rd = 0; force_dok = 0;
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0; last_d[d] = 0; own[d] = 0; wcnt[d] = 0;
            rstn[d] = 0; b_aok[d] = 0; b_dok[d] = 0; b_rdata[d] = 0;
            for (int r = 0; r < 2; r++) begin
                pend[d][r] = 1'b1; rq[d][r] = rand_req(); req_v[d][r] = 1'b1; cnt_aok[d][r] = 0;
            end
        end
        p_new = '{0, 0};

        // Reset with both requests held; data must win the first grant.
        repeat (3) step(1'b1);
        drain();

        // Single data read returning DEADBEEF with minimum latency.
        for (int d = 0; d < 2; d++) begin
            pend[d][1] = 1'b1; rq[d][1] = '{1'b0, 2'd2, 32'h1000_0004, 4'h0, 32'h0};
        end
        aok_delay = 0; force_rd = 1;
        drain();
        force_rd = 0;

        // Write stalled four cycles on the address phase.
        for (int d = 0; d < 2; d++) begin
            pend[d][1] = 1'b1; rq[d][1] = '{1'b1, 2'd2, 32'h2000_0008, 4'b0100, 32'h00AB_0000};
        end
        aok_delay = 4;
        drain();

        // Continuous contention on both requesters.
        for (int d = 0; d < 2; d++) for (int r = 0; r < 2; r++) cnt_aok[d][r] = 0;
        aok_delay = -1; p_dok = 60; p_new = '{100, 100};
        repeat (80) step(1'b0);
        #3;
        ok = cnt_aok[0][0] > 0 && cnt_aok[0][1] > 0 &&
             (cnt_aok[0][0] - cnt_aok[0][1] <= 1) && (cnt_aok[0][1] - cnt_aok[0][0] <= 1);
        chk(ok, "rr_alternation", {cnt_aok[0][0], cnt_aok[0][1]}, 0);
        chk(cnt_aok[1][0] == 0, "strict_inst_starved", cnt_aok[1][0], 0);
        chk(cnt_aok[1][1] > 0, "strict_data_granted", cnt_aok[1][1], 1);
        drain();

        // Random traffic with spurious bus handshakes.
        p_spur = 15; p_dok = 50; p_new = '{30, 30};
        repeat (1500) step(1'b0);
        p_spur = 0; p_dok = 100;
        drain();

        // Reset while in the data phase, then a stray completion.
        for (int d = 0; d < 2; d++) begin
            pend[d][1] = 1'b1; rq[d][1] = '{1'b0, 2'd2, 32'h3000_0000, 4'h0, 32'h0};
        end
        aok_delay = 0; p_dok = 0;
        for (int i = 0; i < 10; i++) begin
            if (ph[0] == 2 && ph[1] == 2) break;
            step(1'b0);
        end
        chk(ph[0] == 2 && ph[1] == 2, "reach_data_phase_timeout", {ph[0], ph[1]}, 2);
        step(1'b1);
        step(1'b1);
        force_dok = 1;
        step(1'b0);
        force_dok = 0;
        step(1'b0);
        #3;
        for (int d = 0; d < 2; d++)
            chk(!o_breq[d] && !o_dok[d][0] && !o_dok[d][1], "post_reset_idle", {o_breq[d], o_dok[d][0], o_dok[d][1]}, 0);
        p_dok = 100;
        drain();

        for (int d = 0; d < 2; d++) begin
            chk(acc_q[d].size() == 0, "pending_addr_ok_left", acc_q[d].size(), 0);
            chk(rsp_q[d].size() == 0, "pending_data_ok_left", rsp_q[d].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
